// File: rtl/pwm_duty_sched.sv
// Round-robin duty scheduler driving one shared free-running PWM counter.
// Define PWM_DUTY_RAMP_EN to ramp duty by STEP per period instead of jumping.
module pwm_duty_sched #(
    parameter int CBITS = 21,
    parameter int DBITS = 3,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [DBITS-1:0] target0,
    input  logic [DBITS-1:0] target1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic [DBITS-1:0] duty,
    output logic             period_end,
    output logic             pulse
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [CBITS-1:0] r_cnt;
    logic [CBITS-1:0] w_thr;
    logic [DBITS-1:0] r_duty;
    logic [DBITS-1:0] r_tgt;
    logic [DBITS-1:0] w_duty_nx;
    logic [DBITS-1:0] w_tgt_nx;
    logic [DBITS-1:0] w_ramp;
    logic             r_gid;
    logic             r_last;
    logic             w_gid_nx;
    logic             w_last_nx;
    logic             r_ack0;
    logic             r_ack1;
    logic             w_ack0_nx;
    logic             w_ack1_nx;
    logic             r_pulse;
    logic             w_pe;

    if (DBITS > CBITS - 1 || STEP < 1 || STEP > (2 ** DBITS) - 1) begin : g_bad_cfg
        $error("pwm_duty_sched: illegal CBITS/DBITS/STEP");
    end

    assign w_pe  = (r_cnt == {CBITS{1'b1}});
    assign w_thr = {{(CBITS-DBITS){1'b0}}, r_duty} << (CBITS - 1 - DBITS);

`ifdef PWM_DUTY_RAMP_EN
    localparam logic [DBITS-1:0] LP_STEP = DBITS'(STEP);

    logic             w_up;
    logic [DBITS-1:0] w_diff;
    logic [DBITS-1:0] w_inc;

    // Step is clamped to the remaining distance so duty never overshoots.
    always_comb begin
        w_up   = (r_tgt > r_duty);
        w_diff = w_up ? (r_tgt - r_duty) : (r_duty - r_tgt);
        w_inc  = (w_diff < LP_STEP) ? w_diff : LP_STEP;
        w_ramp = w_up ? (r_duty + w_inc) : (r_duty - w_inc);
    end
`else
    assign w_ramp = r_tgt;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_duty_nx  = r_duty;
        w_tgt_nx   = r_tgt;
        w_gid_nx   = r_gid;
        w_last_nx  = r_last;
        w_ack0_nx  = 1'b0;
        w_ack1_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_gid_nx   = (req0 && req1) ? ~r_last : req1;
                    w_last_nx  = w_gid_nx;
                    w_tgt_nx   = w_gid_nx ? target1 : target0;
                    w_state_nx = (w_tgt_nx == r_duty) ? S_DONE : S_PEND;
                end
            end
            S_PEND: begin
                if (w_pe) begin
                    w_duty_nx = w_ramp;
                    if (w_ramp == r_tgt) begin
                        w_state_nx = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_ack0_nx  = ~r_gid;
                w_ack1_nx  = r_gid;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_duty  <= '0;
            r_tgt   <= '0;
            r_gid   <= 1'b0;
            r_last  <= 1'b1;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_duty  <= w_duty_nx;
            r_tgt   <= w_tgt_nx;
            r_gid   <= w_gid_nx;
            r_last  <= w_last_nx;
            r_ack0  <= w_ack0_nx;
            r_ack1  <= w_ack1_nx;
            r_pulse <= (r_cnt < w_thr);
        end
    end

    assign ack0       = r_ack0;
    assign ack1       = r_ack1;
    assign busy       = (r_state != S_IDLE);
    assign duty       = r_duty;
    assign period_end = w_pe;
    assign pulse      = r_pulse;

endmodule

// File: tb/tb_pwm_duty_sched.sv
// Scoreboard bench for pwm_duty_sched (CBITS=6, DBITS=3); ack events are
// queued at request time and matched by an independent monitor.
module tb_pwm_duty_sched;

    localparam int CB  = 6;
    localparam int DB  = 3;
    localparam int PER = 64;
`ifdef PWM_DUTY_RAMP_EN
    localparam int ST = 2;
`else
    localparam int ST = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic [DB-1:0] target0 = '0;
    logic [DB-1:0] target1 = '0;
    logic          ack0;
    logic          ack1;
    logic          busy;
    logic [DB-1:0] duty;
    logic          period_end;
    logic          pulse;

    pwm_duty_sched #(
        .CBITS(CB),
        .DBITS(DB),
        .STEP (ST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .target0   (target0),
        .target1   (target1),
        .ack0      (ack0),
        .ack1      (ack1),
        .busy      (busy),
        .duty      (duty),
        .period_end(period_end),
        .pulse     (pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int gid;
        int at;
        int duty;
    } exp_t;

    exp_t q[$];
    int   errs = 0;
    int   checks = 0;
    int   n;

    // Edges since reset release; equals the expected counter value mod PER.
    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (n=%0d)", name, act, exp, n);
        end
    endtask

    function automatic int ack_at(input int k, input int from, input int to);
        int d;
        int p;
        d = (to > from) ? to - from : from - to;
        if (d == 0) return k + 1;
`ifdef PWM_DUTY_RAMP_EN
        p = (d + ST - 1) / ST;
`else
        p = 1;
`endif
        return ((k / PER) + 1) * PER + PER * (p - 1) + 1;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("period_end", int'(period_end), int'((n % PER) == PER - 1));
            if (ack0 || ack1) begin
                chk("single_ack", int'(ack0 && ack1), 0);
                chk("busy_at_ack", int'(busy), 0);
                if (q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_ack: ack0=%0b ack1=%0b n=%0d", ack0, ack1, n);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ack_gid", ack1 ? 1 : 0, e.gid);
                    chk("ack_cycle", n, e.at);
                    chk("ack_duty", int'(duty), e.duty);
                end
            end
        end
    end

    task automatic step(input int c);
        repeat (c) @(negedge clk);
    endtask

    // Acts as both requesters: drop req on own ack, then wait for idle.
    task automatic wait_idle(input int lim);
        bit done;
        done = 1'b0;
        for (int i = 0; i < lim && !done; i++) begin
            @(negedge clk);
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
            if (!req0 && !req1 && !busy) done = 1'b1;
        end
        chk("idle_timeout", int'(done), 1);
    endtask

    task automatic issue(input int g, input int tgt, input int from);
        exp_t e;
        e.gid  = g;
        e.at   = ack_at(n + 1, from, tgt);
        e.duty = tgt;
        q.push_back(e);
        if (g == 0) begin
            target0 = DB'(tgt);
            req0    = 1'b1;
        end else begin
            target1 = DB'(tgt);
            req1    = 1'b1;
        end
    endtask

    task automatic pulse_count(input string name, input int d);
        int c;
        c = 0;
        repeat (PER) begin
            @(negedge clk);
            c += int'(pulse);
        end
        chk(name, c, d << (CB - 1 - DB));
    endtask

    initial begin
        exp_t e0;
        exp_t e1;
        #200000;
        $display("FAIL watchdog: simulation did not finish, n=%0d", n);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e0;
        exp_t e1;
        step(3);
        chk("rst_pulse", int'(pulse), 0);
        chk("rst_duty", int'(duty), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(ack0 | ack1), 0);
        chk("rst_period_end", int'(period_end), 0);
        rst = 1'b0;

        step(5);
        issue(0, 3, 0);
        step(1);
        chk("busy_after_grant", int'(busy), 1);
        wait_idle(400);
        chk("jump_duty", int'(duty), 3);
        pulse_count("pulse_cnt_d3", 3);

        issue(1, 3, 3);
        wait_idle(20);
        chk("same_tgt_duty", int'(duty), 3);
        pulse_count("pulse_cnt_same", 3);

        issue(0, 7, 3);
        wait_idle(400);
        issue(1, 2, 7);
        wait_idle(400);
        chk("down_duty", int'(duty), 2);

        while (n % PER != 0) step(1);
        target0 = 3'd6;
        req0    = 1'b1;
        step(2);
        chk("pend_busy", int'(busy), 1);
        chk("pend_pulse", int'(pulse), 1);
        rst = 1'b1;
        #1;
        chk("arst_pulse", int'(pulse), 0);
        chk("arst_duty", int'(duty), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_ack", int'(ack0 | ack1), 0);
        req0 = 1'b0;
        step(3);
        rst = 1'b0;
        step(140);
        chk("post_rst_duty", int'(duty), 0);
        chk("post_rst_busy", int'(busy), 0);

        step(2);
        e0.gid  = 0;
        e0.at   = ack_at(n + 1, 0, 5);
        e0.duty = 5;
        e1.gid  = 1;
        e1.at   = ack_at(e0.at + 1, 5, 1);
        e1.duty = 1;
        q.push_back(e0);
        q.push_back(e1);
        target0 = 3'd5;
        target1 = 3'd1;
        req0    = 1'b1;
        req1    = 1'b1;
        wait_idle(800);
        chk("tie1_duty", int'(duty), 1);

        step(3);
        e0.gid  = 0;
        e0.at   = ack_at(n + 1, 1, 1);
        e0.duty = 1;
        e1.gid  = 1;
        e1.at   = ack_at(e0.at + 1, 1, 7);
        e1.duty = 7;
        q.push_back(e0);
        q.push_back(e1);
        target0 = 3'd1;
        target1 = 3'd7;
        req0    = 1'b1;
        req1    = 1'b1;
        wait_idle(800);
        chk("tie2_duty", int'(duty), 7);
        pulse_count("pulse_cnt_d7", 7);

        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
